// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memReadEnable;
  logic                  memAck;
  logic [31:0]           memData;

  modport master (
    output memAddress,
    output memReadEnable,
    input  memAck,
    input  memData
  );

  modport slave (
    input  memAddress,
    input  memReadEnable,
    output memAck,
    output memData
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads one instruction per request into the IR and exposes its decoded fields.
// Optional macro FETCH_TIMEOUT_EN adds a bounded WAIT with a sticky fetchTimeout flag.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH        = 32,
  parameter logic [31:0] RESET_INSTRUCTION = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetchRequest,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   pcAddress,
  instruction_fetch_unit_if.master memBus,
  output logic [31:0]             instruction,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [4:0]              rd,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic                    instructionValid,
  output logic                    fetchBusy,
  output logic                    fetchMisaligned,
  output logic                    instructionIllegal,
  output logic                    fetchTimeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

  state_t                state;
  state_t                stateNext;
  logic [31:0]           ir_p0;
  logic [ADDR_WIDTH-1:0] memAddress_p0;
  logic                  vld_p0;
  logic                  misaligned_p0;
  logic                  readEnable;
  logic                  busy;
  logic                  timeoutHit;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] waitCount;
  logic       timeout_p0;

  // Limit is reached on the cycle whose increment would hit it; an ack or flush that cycle wins.
  assign timeoutHit = (state == WAIT) && !flush && !memBus.memAck &&
                      ((waitCount + 8'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCount  <= 8'd0;
      timeout_p0 <= 1'b0;
    end else begin
      if (state == WAIT && !memBus.memAck)
        waitCount <= waitCount + 8'd1;
      else
        waitCount <= 8'd0;
      if (timeoutHit)
        timeout_p0 <= 1'b1;
    end
  end

  assign fetchTimeout = timeout_p0;
`else
  assign timeoutHit   = 1'b0;
  assign fetchTimeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:
        if (!flush && fetchRequest)
          stateNext = (pcAddress[1:0] != 2'b00) ? ERROR : WAIT;
      WAIT:
        if (flush || memBus.memAck)
          stateNext = IDLE;
        else if (timeoutHit)
          stateNext = ERROR;
      default:
        stateNext = ERROR;
    endcase
  end

  // Read strobe follows the state register so reset removes it asynchronously.
  always_comb begin
    readEnable = 1'b0;
    busy       = 1'b0;
    if (state == WAIT) begin
      readEnable = 1'b1;
      busy       = 1'b1;
    end
  end

  // Stage p0: fetch address, instruction register and its valid flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_p0         <= RESET_INSTRUCTION;
      memAddress_p0 <= '0;
      vld_p0        <= 1'b0;
      misaligned_p0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            vld_p0 <= 1'b0;
          end else if (fetchRequest) begin
            vld_p0 <= 1'b0;
            if (pcAddress[1:0] != 2'b00)
              misaligned_p0 <= 1'b1;
            else
              memAddress_p0 <= pcAddress;
          end
        end
        WAIT: begin
          if (flush) begin
            vld_p0 <= 1'b0;
          end else if (memBus.memAck) begin
            ir_p0  <= memBus.memData;
            vld_p0 <= 1'b1;
          end
        end
        default: vld_p0 <= 1'b0;
      endcase
    end
  end

  assign memBus.memAddress    = memAddress_p0;
  assign memBus.memReadEnable = readEnable;
  assign fetchBusy            = busy;
  assign fetchMisaligned      = misaligned_p0;

  assign instruction        = ir_p0;
  assign opcode             = ir_p0[6:0];
  assign rd                 = ir_p0[11:7];
  assign funct3             = ir_p0[14:12];
  assign rs1                = ir_p0[19:15];
  assign rs2                = ir_p0[24:20];
  assign funct7             = ir_p0[31:25];
  assign instructionValid   = vld_p0;
  assign instructionIllegal = vld_p0 && (ir_p0[1:0] != 2'b11);

endmodule
